core_bus_arbiter: RTL and testbench

Single-master arbiter sitting directly downstream of the pipelined core. It merges the core's instruction-fetch port (ibus) and data port (dbus) onto one single-beat memory request port. Requests are latched at grant, held stable toward memory until accepted, and the response is routed back to the winning port. Ties are resolved round-robin so neither port can starve the other.

---
 rtl/core_bus_arbiter_if.sv | 43 ++++
 rtl/core_bus_arbiter.sv | 104 ++++++++++
 tb/tb_core_bus_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_bus_arbiter_if.sv
// core_bus_arbiter_if: ibus/dbus requests plus the merged memory port.
// slave = arbiter side; master = core and memory side.
interface core_bus_arbiter_if;
  logic        i_valid;
  logic [63:0] i_addr;
  logic        i_addr_ok;
  logic        i_data_ok;
  logic [31:0] i_data;
  logic        d_valid;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic [63:0] d_wdata;
  logic        d_addr_ok;
  logic        d_data_ok;
  logic [63:0] d_rdata;
  logic        m_valid;
  logic        m_is_write;
  logic [63:0] m_addr;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;
  logic [63:0] m_wdata;
  logic        m_ready;
  logic [63:0] m_rdata;

  modport slave (
    input  i_valid, i_addr,
    output i_addr_ok, i_data_ok, i_data,
    input  d_valid, d_addr, d_size, d_strobe, d_wdata,
    output d_addr_ok, d_data_ok, d_rdata,
    output m_valid, m_is_write, m_addr, m_size, m_strobe, m_wdata,
    input  m_ready, m_rdata
  );

  modport master (
    output i_valid, i_addr,
    input  i_addr_ok, i_data_ok, i_data,
    output d_valid, d_addr, d_size, d_strobe, d_wdata,
    input  d_addr_ok, d_data_ok, d_rdata,
    input  m_valid, m_is_write, m_addr, m_size, m_strobe, m_wdata,
    output m_ready, m_rdata
  );
endinterface

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: merges ibus and dbus onto one single-beat
// memory port, round-robin on ties, request latched at grant.
module core_bus_arbiter (
  input logic               clk,
  input logic               reset,
  core_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  state_t      state;
  logic        last_grant;
  logic        m_valid_q;
  logic        m_is_write_q;
  logic [63:0] m_addr_q;
  logic [2:0]  m_size_q;
  logic [7:0]  m_strobe_q;
  logic [63:0] m_wdata_q;

  logic grant_d;
  logic grant_i;
  logic done_i;
  logic done_d;

  // last_grant=0 means I went last, so a tie goes to D
  assign grant_d = bus.d_valid &
                   (~bus.i_valid | ~last_grant);
  assign grant_i = bus.i_valid & ~grant_d;

  assign done_i = (state == BUSY_I) & bus.m_ready;
  assign done_d = (state == BUSY_D) & bus.m_ready;

  assign bus.i_addr_ok = done_i;
  assign bus.i_data_ok = done_i;
  assign bus.d_addr_ok = done_d;
  assign bus.d_data_ok = done_d;

  // fetch address bit 2 picks the instruction word
  assign bus.i_data = m_addr_q[2] ? bus.m_rdata[63:32]
                                  : bus.m_rdata[31:0];
  assign bus.d_rdata = bus.m_rdata;

  assign bus.m_valid    = m_valid_q;
  assign bus.m_is_write = m_is_write_q;
  assign bus.m_addr     = m_addr_q;
  assign bus.m_size     = m_size_q;
  assign bus.m_strobe   = m_strobe_q;
  assign bus.m_wdata    = m_wdata_q;

  // grant FSM; latches the winning request into the m_* registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b0;
      m_valid_q    <= 1'b0;
      m_is_write_q <= 1'b0;
      m_addr_q     <= '0;
      m_size_q     <= '0;
      m_strobe_q   <= '0;
      m_wdata_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            grant_d: begin
              state        <= BUSY_D;
              last_grant   <= 1'b1;
              m_valid_q    <= 1'b1;
              m_is_write_q <= |bus.d_strobe;
              m_addr_q     <= bus.d_addr;
              m_size_q     <= bus.d_size;
              m_strobe_q   <= bus.d_strobe;
              m_wdata_q    <= bus.d_wdata;
            end
            grant_i: begin
              state        <= BUSY_I;
              last_grant   <= 1'b0;
              m_valid_q    <= 1'b1;
              m_is_write_q <= 1'b0;
              m_addr_q     <= bus.i_addr;
              m_size_q     <= 3'b010;
              m_strobe_q   <= '0;
              m_wdata_q    <= '0;
            end
            default: ;
          endcase
        end
        BUSY_I, BUSY_D: begin
          if (bus.m_ready) begin
            state     <= IDLE;
            m_valid_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: vector table for reset and round-robin,
// hand sequences for fetch, store, mid-flight change, reset abort.
module tb_core_bus_arbiter;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  core_bus_arbiter_if bus ();

  core_bus_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] IA = 64'h0000_0000_0000_0100;
  localparam logic [63:0] DA = 64'h0000_0000_0000_0200;
  localparam logic [63:0] RD = 64'hAAAA_BBBB_CCCC_DDDD;

  typedef struct {
    logic        rst;
    logic        iv;
    logic        dv;
    logic        rdy;
    logic        ev;
    logic        ew;
    logic [63:0] ea;
    logic        eio;
    logic        edo;
  } vec_t;

  vec_t v [21];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.i_valid  = 1'b0;
    bus.d_valid  = 1'b0;
    bus.m_ready  = 1'b0;
    bus.d_strobe = 8'h00;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    v[0]  = '{1, 1, 0, 0, 0, 0, 64'h0, 0, 0};
    v[1]  = '{1, 1, 0, 0, 0, 0, 64'h0, 0, 0};
    v[2]  = '{1, 1, 0, 0, 0, 0, 64'h0, 0, 0};
    v[3]  = '{0, 1, 0, 0, 0, 0, 64'h0, 0, 0};
    v[4]  = '{0, 1, 0, 0, 1, 0, IA, 0, 0};
    v[5]  = '{0, 1, 1, 1, 1, 0, IA, 1, 0};
    v[6]  = '{0, 1, 1, 1, 0, 0, 64'h0, 0, 0};
    v[7]  = '{0, 1, 1, 1, 1, 0, DA, 0, 1};
    v[8]  = '{0, 1, 1, 1, 0, 0, 64'h0, 0, 0};
    v[9]  = '{0, 1, 1, 1, 1, 0, IA, 1, 0};
    v[10] = '{0, 1, 1, 1, 0, 0, 64'h0, 0, 0};
    v[11] = '{0, 1, 1, 1, 1, 0, DA, 0, 1};
    v[12] = '{1, 1, 1, 1, 0, 0, 64'h0, 0, 0};
    v[13] = '{0, 1, 1, 1, 0, 0, 64'h0, 0, 0};
    v[14] = '{0, 1, 1, 1, 1, 0, DA, 0, 1};
    v[15] = '{0, 1, 1, 1, 0, 0, 64'h0, 0, 0};
    v[16] = '{0, 1, 1, 1, 1, 0, IA, 1, 0};
    v[17] = '{0, 1, 1, 1, 0, 0, 64'h0, 0, 0};
    v[18] = '{0, 1, 1, 1, 1, 0, DA, 0, 1};
    v[19] = '{0, 1, 1, 1, 0, 0, 64'h0, 0, 0};
    v[20] = '{0, 1, 1, 1, 1, 0, IA, 1, 0};

    reset        = 1'b1;
    bus.i_addr   = IA;
    bus.d_addr   = DA;
    bus.d_size   = 3'd3;
    bus.d_wdata  = 64'h0;
    bus.m_rdata  = RD;
    idle_in();
    step();

    for (int k = 0; k < 21; k++) begin
      reset       = v[k].rst;
      bus.i_valid = v[k].iv;
      bus.d_valid = v[k].dv;
      bus.m_ready = v[k].rdy;
      #1;
      chk($sformatf("v%0d m_valid", k),
          64'(bus.m_valid), 64'(v[k].ev));
      chk($sformatf("v%0d i_addr_ok", k),
          64'(bus.i_addr_ok), 64'(v[k].eio));
      chk($sformatf("v%0d i_data_ok", k),
          64'(bus.i_data_ok), 64'(v[k].eio));
      chk($sformatf("v%0d d_addr_ok", k),
          64'(bus.d_addr_ok), 64'(v[k].edo));
      chk($sformatf("v%0d d_data_ok", k),
          64'(bus.d_data_ok), 64'(v[k].edo));
      if (v[k].ev) begin
        chk($sformatf("v%0d m_addr", k),
            bus.m_addr, v[k].ea);
        chk($sformatf("v%0d m_is_write", k),
            64'(bus.m_is_write), 64'(v[k].ew));
      end
      if (v[k].eio)
        chk($sformatf("v%0d i_data", k),
            64'(bus.i_data), 64'h0000_0000_CCCC_DDDD);
      if (v[k].edo)
        chk($sformatf("v%0d d_rdata", k),
            bus.d_rdata, RD);
      step();
    end

    // fetch, upper word, two wait cycles
    reset = 1'b0;
    idle_in();
    step();
    bus.i_valid = 1'b1;
    bus.i_addr  = 64'h0000_0000_8000_0004;
    step();
    bus.i_valid = 1'b0;
    bus.i_addr  = 64'h0;
    for (int w = 0; w < 2; w++) begin
      #1;
      chk("fetch m_valid", 64'(bus.m_valid), 64'd1);
      chk("fetch m_size", 64'(bus.m_size), 64'd2);
      chk("fetch m_is_write", 64'(bus.m_is_write), 64'd0);
      chk("fetch m_addr", bus.m_addr,
          64'h0000_0000_8000_0004);
      chk("fetch early ok", 64'(bus.i_data_ok), 64'd0);
      step();
    end
    bus.m_ready = 1'b1;
    bus.m_rdata = 64'h1122_3344_5566_7788;
    #1;
    chk("fetch i_data_ok", 64'(bus.i_data_ok), 64'd1);
    chk("fetch i_data", 64'(bus.i_data),
        64'h0000_0000_1122_3344);
    chk("fetch d_data_ok", 64'(bus.d_data_ok), 64'd0);
    step();
    bus.m_ready = 1'b0;
    #1;
    chk("fetch ok pulse", 64'(bus.i_data_ok), 64'd0);
    chk("fetch idle", 64'(bus.m_valid), 64'd0);

    // store, fields held until accepted
    bus.d_valid  = 1'b1;
    bus.d_addr   = 64'h0000_0000_8000_1000;
    bus.d_size   = 3'd3;
    bus.d_strobe = 8'hFF;
    bus.d_wdata  = 64'hDEAD_BEEF_0000_0001;
    step();
    idle_in();
    bus.d_wdata = 64'h0;
    bus.d_size  = 3'd0;
    for (int w = 0; w < 2; w++) begin
      #1;
      chk("store m_is_write", 64'(bus.m_is_write), 64'd1);
      chk("store m_addr", bus.m_addr,
          64'h0000_0000_8000_1000);
      chk("store m_size", 64'(bus.m_size), 64'd3);
      chk("store m_strobe", 64'(bus.m_strobe), 64'hFF);
      chk("store m_wdata", bus.m_wdata,
          64'hDEAD_BEEF_0000_0001);
      step();
    end
    bus.m_ready = 1'b1;
    #1;
    chk("store d_data_ok", 64'(bus.d_data_ok), 64'd1);
    chk("store i_data_ok", 64'(bus.i_data_ok), 64'd0);
    step();
    bus.m_ready = 1'b0;
    #1;
    chk("store ok pulse", 64'(bus.d_data_ok), 64'd0);

    // mid-flight change after a D grant
    bus.d_valid  = 1'b1;
    bus.d_addr   = 64'h0000_0000_0000_3000;
    bus.d_strobe = 8'h00;
    bus.d_size   = 3'd2;
    step();
    bus.d_addr  = 64'h0000_0000_0000_4000;
    bus.i_valid = 1'b1;
    bus.i_addr  = 64'h0000_0000_0000_5000;
    step();
    #1;
    chk("mid m_addr", bus.m_addr,
        64'h0000_0000_0000_3000);
    chk("mid i_ok", 64'(bus.i_data_ok), 64'd0);
    bus.m_ready = 1'b1;
    #1;
    chk("mid d_data_ok", 64'(bus.d_data_ok), 64'd1);
    step();
    bus.m_ready = 1'b0;
    #1;
    chk("mid idle", 64'(bus.m_valid), 64'd0);
    step();
    bus.i_valid = 1'b0;
    bus.d_valid = 1'b0;
    #1;
    chk("mid next m_valid", 64'(bus.m_valid), 64'd1);
    chk("mid next m_addr", bus.m_addr,
        64'h0000_0000_0000_5000);
    chk("mid next m_size", 64'(bus.m_size), 64'd2);

    // reset aborts BUSY_I; later m_ready is ignored
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("abort m_valid", 64'(bus.m_valid), 64'd0);
    chk("abort m_addr", bus.m_addr, 64'h0);
    bus.m_ready = 1'b1;
    #1;
    chk("abort i_data_ok", 64'(bus.i_data_ok), 64'd0);
    chk("abort d_data_ok", 64'(bus.d_data_ok), 64'd0);
    step();
    #1;
    chk("abort stay idle", 64'(bus.m_valid), 64'd0);
    chk("abort late ok", 64'(bus.i_addr_ok), 64'd0);
    bus.m_ready = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
